tl_ul_ram_responder: RTL and testbench
======================================

// Module: tl_ul_ram_responder
// PURPOSE
//  TileLink-UL responder (slave end) for the 12-bit-address, 32-bit-data, 4-bit-mask
//  port checked by the TL monitor wrappers. Accepts A-channel Get/PutFull/PutPartial/Hint,
//  services them from an internal word-addressed RAM, returns D-channel acks via a
//  2-entry response queue. Used as a scratch/peripheral backing store on the local bus.
// PARAMETERS
//  DEPTH     256  number of 32-bit words implemented (1..1024); word index = a_address[11:2]
//  SOURCE_W  2    width of a_source/d_source
// PORTS
//  clock      in   1         single clock, all state on rising edge
//  reset      in   1         synchronous, active-high
//  a_valid    in   1         A request valid
//  a_ready    out  1         A request accepted when a_valid & a_ready
//  a_opcode   in   3         0 PutFull, 1 PutPartial, 2 Arith, 3 Logical, 4 Get, 5 Hint
//  a_param    in   3         ignored (UL)
//  a_size     in   2         log2 bytes (0..2 legal; 3 illegal)
//  a_source   in   SOURCE_W  request id, echoed on D
//  a_address  in   12        byte address
//  a_mask     in   4         byte lanes
//  a_data     in   32        write data
//  d_valid    out  1         D response valid
//  d_ready    in   1         D response accepted when d_valid & d_ready
//  d_opcode   out  3         0 AccessAck, 1 AccessAckData, 2 HintAck
//  d_param    out  2         always 0
//  d_size     out  2         echo of a_size
//  d_source   out  SOURCE_W  echo of a_source
//  d_denied   out  1         request rejected, no side effect
//  d_corrupt  out  1         data invalid (set on denied data responses)
//  d_data     out  32        read data (0 when d_opcode != 1)
// BEHAVIOUR
//  - Reset: queue count=0; d_valid=0, a_ready=1; all D payload outputs 0. RAM not reset.
//  - a_ready = (count < 2); no combinational path from d_ready to a_ready.
//  - A fire at edge N: response pushed to queue; d_valid=1 from cycle N+1 (latency 1).
//  - d_valid = (count != 0); D payload = head entry, held stable while d_valid & !d_ready.
//  - Count: push only -> +1; pop only -> -1; push & pop (count==1) -> unchanged.
//    Push at count==2 impossible (a_ready=0). Queue order strictly FIFO.
//  - Denied (d_denied=1, no RAM access) if any: a_size==3; address misaligned to
//    a_size; word index >= DEPTH; a_opcode in {2,3}; a_opcode in {6,7}.
//  - Response opcode: 0/1 -> AccessAck; 2/3/4 -> AccessAckData; 5 -> HintAck;
//    6/7 -> AccessAck. d_corrupt = d_denied & (d_opcode==1). Denied data = 0.
//  - PutFull/PutPartial (not denied): write byte lanes where a_mask[i]=1 at fire edge.
//  - Get (not denied): d_data = RAM word sampled at fire edge (pre-write; only one A
//    per cycle, so a Get fired after a Put fire returns the Put data).
//  - Hint: no RAM effect, never denied unless size/alignment/range rule fails.
//  - Reset mid-operation: queue flushed, pending responses dropped, RAM contents kept;
//    a_ready=1 first cycle after reset.
// TESTING
//  - Reset 3 cycles -> d_valid=0, a_ready=1, d_opcode/d_data=0.
//  - PutFull addr 0x010 data 0xDEADBEEF mask F src 1, then Get addr 0x010 size 2 src 2
//    -> AccessAck src1, then AccessAckData src2 data 0xDEADBEEF, each 1 cycle after fire.
//  - PutPartial addr 0x010 mask 0x3 data 0x00001234, Get -> data 0xDEAD1234.
//  - Hold d_ready=0, fire 2 Gets -> a_ready=0 after 2nd fire, d payload stable;
//    release d_ready -> responses in order, a_ready back to 1 after first pop.
//  - Get addr 0x400 (index 256 >= DEPTH) -> d_denied=1, d_corrupt=1, d_data=0;
//    Get addr 0x002 size 2 -> denied; opcode 2 -> AccessAckData denied corrupt.
//  - Reset asserted with 2 queued responses -> d_valid=0 next cycle, RAM data retained.

Source files
------------

// File: rtl/tl_ul_ram_responder.sv
// rtl/tl_ul_ram_responder.sv - TileLink-UL RAM responder with 2-entry D-channel response queue
module tl_ul_ram_responder #(
    parameter int DEPTH    = 256,
    parameter int SOURCE_W = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [2:0]          a_opcode,
    input  logic [2:0]          a_param,
    input  logic [1:0]          a_size,
    input  logic [SOURCE_W-1:0] a_source,
    input  logic [11:0]         a_address,
    input  logic [3:0]          a_mask,
    input  logic [31:0]         a_data,
    output logic                d_valid,
    input  logic                d_ready,
    output logic [2:0]          d_opcode,
    output logic [1:0]          d_param,
    output logic [1:0]          d_size,
    output logic [SOURCE_W-1:0] d_source,
    output logic                d_denied,
    output logic                d_corrupt,
    output logic [31:0]         d_data
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [2:0]          op;
        logic [1:0]          size;
        logic [SOURCE_W-1:0] src;
        logic                denied;
        logic [31:0]         data;
    } resp_t;

    logic [31:0] mem_q [DEPTH];

    logic [1:0] count_q, count_d;
    resp_t      slot0_q, slot0_d;
    resp_t      slot1_q, slot1_d;

    logic       a_fire, d_pop;
    logic [9:0] word_idx;
    logic       req_denied, wr_en;
    logic [2:0] resp_op;
    logic [31:0] rd_word;
    resp_t      new_entry;
    logic       unused_a_param;

    assign unused_a_param = ^a_param;

    // Request decode: the denial rules gate every RAM access below.
    always_comb begin
        word_idx   = a_address[11:2];
        req_denied = (a_size == 2'd3)
                   || ((a_size == 2'd1) && a_address[0])
                   || ((a_size == 2'd2) && (a_address[1:0] != 2'b00))
                   || ({1'b0, word_idx} >= 11'(DEPTH))
                   || (a_opcode inside {3'd2, 3'd3, 3'd6, 3'd7});
        case (a_opcode)
            3'd2, 3'd3, 3'd4: resp_op = 3'd1;
            3'd5:             resp_op = 3'd2;
            default:          resp_op = 3'd0;
        endcase
        rd_word          = mem_q[word_idx[IDX_W-1:0]];
        new_entry.op     = resp_op;
        new_entry.size   = a_size;
        new_entry.src    = a_source;
        new_entry.denied = req_denied;
        new_entry.data   = ((a_opcode == 3'd4) && !req_denied) ? rd_word : 32'd0;
    end

    assign a_ready = (count_q < 2'd2);
    assign d_valid = (count_q != 2'd0);
    assign a_fire  = a_valid & a_ready;
    assign d_pop   = d_valid & d_ready;
    assign wr_en   = a_fire && !reset && !req_denied
                   && ((a_opcode == 3'd0) || (a_opcode == 3'd1));

    // Shift-register FIFO: slot0 is always the head.
    always_comb begin
        count_d = count_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        case ({a_fire, d_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (d_pop) begin
            slot0_d = slot1_q;
        end
        if (a_fire) begin
            if ((count_q == 2'd0) || ((count_q == 2'd1) && d_pop)) begin
                slot0_d = new_entry;
            end else begin
                slot1_d = new_entry;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= 2'd0;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            count_q <= count_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

    // RAM is deliberately left out of reset so contents survive a bus reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (a_mask[i]) begin
                    mem_q[word_idx[IDX_W-1:0]][8*i +: 8] <= a_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        d_param   = 2'd0;
        d_opcode  = d_valid ? slot0_q.op   : 3'd0;
        d_size    = d_valid ? slot0_q.size : 2'd0;
        d_source  = d_valid ? slot0_q.src  : '0;
        d_denied  = d_valid & slot0_q.denied;
        d_corrupt = d_valid & slot0_q.denied & (slot0_q.op == 3'd1);
        d_data    = d_valid ? slot0_q.data : 32'd0;
    end

endmodule

// File: tb/tb_tl_ul_ram_responder.sv
// tb/tb_tl_ul_ram_responder.sv - randomized bench for tl_ul_ram_responder against a queue/array model
module tb_tl_ul_ram_responder;

    localparam int DEPTH = 256;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [1:0]  a_source;
    logic [11:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [1:0]  d_size;
    logic [1:0]  d_source;
    logic        d_denied;
    logic        d_corrupt;
    logic [31:0] d_data;

    tl_ul_ram_responder #(.DEPTH(DEPTH), .SOURCE_W(2)) dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_source(d_source), .d_denied(d_denied), .d_corrupt(d_corrupt),
        .d_data(d_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [1:0]  src;
        logic        denied;
        logic        corrupt;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_m [DEPTH];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("a_ready", 32'(a_ready), 32'(exp_q.size() < 2));
        check("d_valid", 32'(d_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("d_opcode",  32'(d_opcode),  32'(exp_q[0].op));
            check("d_param",   32'(d_param),   32'd0);
            check("d_size",    32'(d_size),    32'(exp_q[0].size));
            check("d_source",  32'(d_source),  32'(exp_q[0].src));
            check("d_denied",  32'(d_denied),  32'(exp_q[0].denied));
            check("d_corrupt", 32'(d_corrupt), 32'(exp_q[0].corrupt));
            check("d_data",    d_data,         exp_q[0].data);
        end
    endtask

    // One bus cycle: check current outputs, drive new inputs, advance the model
    // by the handshakes that will happen on the coming rising edge.
    task automatic step(input bit av, input logic [2:0] op, input logic [1:0] sz,
                        input logic [1:0] src, input logic [11:0] addr,
                        input logic [3:0] mask, input logic [31:0] data, input bit dr);
        bit   fire, pop, denied;
        int   idx;
        exp_t e;
        @(negedge clock);
        check_outputs();
        a_valid   = av;
        a_opcode  = op;
        a_param   = 3'($urandom);
        a_size    = sz;
        a_source  = src;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        d_ready   = dr;
        fire = av && (exp_q.size() < 2);
        pop  = dr && (exp_q.size() != 0);
        if (pop) void'(exp_q.pop_front());
        if (fire) begin
            idx    = int'(addr) / 4;
            denied = (sz == 2'd3) || ((int'(addr) % (1 << sz)) != 0) || (idx >= DEPTH)
                     || (op == 3'd2) || (op == 3'd3) || (op == 3'd6) || (op == 3'd7);
            e.op      = (op == 3'd2 || op == 3'd3 || op == 3'd4) ? 3'd1 :
                        (op == 3'd5) ? 3'd2 : 3'd0;
            e.size    = sz;
            e.src     = src;
            e.denied  = denied;
            e.corrupt = denied && (e.op == 3'd1);
            e.data    = (op == 3'd4 && !denied) ? mem_m[idx] : 32'd0;
            exp_q.push_back(e);
            if (!denied && (op == 3'd0 || op == 3'd1)) begin
                for (int i = 0; i < 4; i++)
                    if (mask[i]) mem_m[idx][8*i +: 8] = data[8*i +: 8];
            end
        end
    endtask

    task automatic idle(input int n, input bit dr);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 2'd2, 2'd0, 12'd0, 4'h0, 32'd0, dr);
    endtask

    task automatic do_reset(input int n);
        @(negedge clock);
        reset   = 1'b1;
        a_valid = 1'b0;
        d_ready = 1'b0;
        repeat (n) @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        check("rst_d_valid",  32'(d_valid),  32'd0);
        check("rst_a_ready",  32'(a_ready),  32'd1);
        check("rst_d_opcode", 32'(d_opcode), 32'd0);
        check("rst_d_data",   d_data,        32'd0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [1:0]  sz;
        logic [11:0] addr;
        logic [2:0]  op_pick [5];
        op_pick = '{3'd0, 3'd1, 3'd4, 3'd4, 3'd5};

        reset = 1'b1; a_valid = 1'b0; d_ready = 1'b0; a_opcode = 3'd0; a_param = 3'd0;
        a_size = 2'd2; a_source = 2'd0; a_address = 12'd0; a_mask = 4'h0; a_data = 32'd0;
        do_reset(3);

        // Initialise the whole RAM so every later read has a known value.
        for (int w = 0; w < DEPTH; w++)
            step(1'b1, 3'd0, 2'd2, 2'($urandom), 12'(w * 4), 4'hF, $urandom, 1'b1);
        idle(2, 1'b1);

        // Directed scenarios.
        step(1'b1, 3'd0, 2'd2, 2'd1, 12'h010, 4'hF, 32'hDEADBEEF, 1'b1);
        step(1'b1, 3'd4, 2'd2, 2'd2, 12'h010, 4'h0, 32'd0, 1'b1);
        idle(2, 1'b1);
        step(1'b1, 3'd1, 2'd2, 2'd0, 12'h010, 4'h3, 32'h00001234, 1'b1);
        step(1'b1, 3'd4, 2'd2, 2'd3, 12'h010, 4'h0, 32'd0, 1'b1);
        idle(2, 1'b1);
        check("partial_model", mem_m[4], 32'hDEAD1234);
        step(1'b1, 3'd4, 2'd2, 2'd1, 12'h010, 4'h0, 32'd0, 1'b0);
        step(1'b1, 3'd4, 2'd2, 2'd2, 12'h020, 4'h0, 32'd0, 1'b0);
        step(1'b1, 3'd4, 2'd2, 2'd3, 12'h030, 4'h0, 32'd0, 1'b0);
        idle(3, 1'b0);
        idle(4, 1'b1);
        step(1'b1, 3'd4, 2'd2, 2'd0, 12'h400, 4'h0, 32'd0, 1'b1);
        step(1'b1, 3'd4, 2'd2, 2'd1, 12'h002, 4'h0, 32'd0, 1'b1);
        step(1'b1, 3'd2, 2'd2, 2'd2, 12'h010, 4'hF, 32'h1, 1'b1);
        step(1'b1, 3'd5, 2'd0, 2'd3, 12'h013, 4'h0, 32'd0, 1'b1);
        step(1'b1, 3'd7, 2'd1, 2'd0, 12'h012, 4'h0, 32'd0, 1'b1);
        idle(3, 1'b1);

        // Reset with two queued responses; RAM must survive it.
        step(1'b1, 3'd0, 2'd2, 2'd1, 12'h040, 4'hF, 32'hCAFEF00D, 1'b0);
        step(1'b1, 3'd4, 2'd2, 2'd2, 12'h040, 4'h0, 32'd0, 1'b0);
        idle(1, 1'b0);
        do_reset(1);
        step(1'b1, 3'd4, 2'd2, 2'd2, 12'h040, 4'h0, 32'd0, 1'b1);
        idle(2, 1'b1);
        check("retained_model", mem_m[16], 32'hCAFEF00D);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            sz = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
            addr = ($urandom_range(0, 9) == 0) ? 12'($urandom) : 12'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) addr = addr & ~12'((1 << sz) - 1);
            op = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7))
                                             : op_pick[$urandom_range(0, 4)];
            step($urandom_range(0, 2) != 0, op, sz, 2'($urandom), addr, 4'($urandom),
                 $urandom, $urandom_range(0, 3) != 0);
            if (c == 1500) do_reset(2);
        end
        idle(4, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
